// File: rtl/trapezoid_feeder.sv
// Host-side feeder for the trapezoid engine: buffers descriptors, drives the nt/xi/yi
// load sequence, then counts po strobes until busy drops or the watchdog expires.
module trapezoid_feeder #(
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 65535
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             desc_valid,
   output logic             desc_ready,
   input  logic [7:0]       desc_xul,
   input  logic [7:0]       desc_xur,
   input  logic [7:0]       desc_xdl,
   input  logic [7:0]       desc_xdr,
   input  logic [7:0]       desc_yu,
   input  logic [7:0]       desc_yd,
   output logic             nt,
   output logic [7:0]       xi,
   output logic [7:0]       yi,
   input  logic             busy_in,
   input  logic             po_in,
   output logic [CNT_W-1:0] pix_count,
   output logic             done,
   output logic             timeout
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
   localparam logic [CNT_W-1:0] PIX_ONE = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, L0, L1, L2, L3, WAIT, REPORT} state_t;

   state_t           state, next_state;
   logic [47:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count, count_next;
   logic             push, pop;
   logic [47:0]      head;
   logic [7:0]       w_xur, w_xdl, w_xdr, w_yd;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [WD_W-1:0]  wd;
   logic             finish_ok, wd_fire;

   assign push = desc_valid && desc_ready;
   assign pop  = (state == IDLE) && (count != '0) && !busy_in;
   // Head layout: {xul, xur, xdl, xdr, yu, yd}
   assign head = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {desc_xul, desc_xur, desc_xdl, desc_xdr, desc_yu, desc_yd};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         desc_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count      <= count_next;
         desc_ready <= (count_next != FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      finish_ok  = 1'b0;
      wd_fire    = 1'b0;
      case (state)
         IDLE:   if (pop) next_state = L0;
         L0:     next_state = L1;
         L1:     next_state = L2;
         L2:     next_state = L3;
         L3:     next_state = WAIT;
         WAIT: begin
            // Engine completion wins over a watchdog expiring in the same cycle.
            if (!busy_in) begin
               next_state = REPORT;
               finish_ok  = 1'b1;
            end else if (wd == WD_LAST) begin
               next_state = REPORT;
               wd_fire    = 1'b1;
            end
         end
         REPORT: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cnt_next = cnt;
      if (pop)
         cnt_next = '0;
      else if (po_in && (state inside {L1, L2, L3, WAIT}) && (cnt != '1))
         cnt_next = cnt + PIX_ONE;
   end

   // Outputs are registered from next_state so they line up with the state's own cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         wd        <= '0;
         pix_count <= '0;
         done      <= 1'b0;
         timeout   <= 1'b0;
         nt        <= 1'b0;
         xi        <= '0;
         yi        <= '0;
         w_xur     <= '0;
         w_xdl     <= '0;
         w_xdr     <= '0;
         w_yd      <= '0;
      end else begin
         cnt     <= cnt_next;
         wd      <= (state == WAIT) ? wd + WD_ONE : '0;
         done    <= finish_ok;
         timeout <= wd_fire;
         if (finish_ok || wd_fire) pix_count <= cnt_next;
         if (pop) begin
            w_xur <= head[39:32];
            w_xdl <= head[31:24];
            w_xdr <= head[23:16];
            w_yd  <= head[7:0];
         end
         nt <= (next_state == L0);
         case (next_state)
            L0: begin
               xi <= head[47:40];
               yi <= head[15:8];
            end
            L1: begin
               xi <= w_xur;
               yi <= '0;
            end
            L2: begin
               xi <= w_xdl;
               yi <= w_yd;
            end
            L3: begin
               xi <= w_xdr;
               yi <= '0;
            end
            default: begin
               xi <= '0;
               yi <= '0;
            end
         endcase
      end
   end

endmodule
